// File: rtl/apb_fsm_controller.sv
// APB sequencing state machine of the AHB-to-APB bridge.
// Drives SETUP/ENABLE phases for single, back-to-back and pipelined
// transfers, and stalls the AHB master through Hreadyout during SETUP.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | no APB transfer; ready for AHB
// WWAIT    | write accepted, waiting one cycle for Hwdata
// READ     | read SETUP phase
// WRITE    | write SETUP phase, no further transfer pending
// WRITEP   | write SETUP phase, another transfer pending
// RENABLE  | read ENABLE phase
// WENABLE  | write ENABLE phase, nothing pending
// WENABLEP | write ENABLE phase, pending transfer follows directly
module apb_fsm_controller (
    input  logic        Hclk,
    input  logic        Hresetn,
    input  logic        valid,
    input  logic        Hwrite,
    input  logic        Hwritereg,
    input  logic [31:0] Haddr,
    input  logic [31:0] Haddr1,
    input  logic [31:0] Haddr2,
    input  logic [31:0] Hwdata,
    input  logic [31:0] Hwdata1,
    input  logic [31:0] Hwdata2,
    input  logic [31:0] Prdata,
    input  logic [2:0]  tempselx,
    output logic        Pwrite,
    output logic        Penable,
    output logic [2:0]  Pselx,
    output logic [31:0] Paddr,
    output logic [31:0] Pwdata,
    output logic        Hreadyout
);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_WWAIT    = 3'd1;
    localparam logic [2:0] ST_READ     = 3'd2;
    localparam logic [2:0] ST_WRITE    = 3'd3;
    localparam logic [2:0] ST_WRITEP   = 3'd4;
    localparam logic [2:0] ST_RENABLE  = 3'd5;
    localparam logic [2:0] ST_WENABLE  = 3'd6;
    localparam logic [2:0] ST_WENABLEP = 3'd7;

    logic [2:0]  state_q, state_d;
    logic [31:0] paddr_q, paddr_d;
    logic [31:0] pwdata_q, pwdata_d;
    logic        pwrite_q, pwrite_d;
    logic [2:0]  pselx_q, pselx_d;
    logic        penable_q, penable_d;
    logic        hreadyout_q, hreadyout_d;

    // Delayed data copies and read data are routed by the bridge top, not here.
    logic unused_inputs;
    assign unused_inputs = ^{Hwdata1, Hwdata2, Prdata};

    // Next state and next registered output values.
    always_comb begin
        state_d     = state_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        pwrite_d    = pwrite_q;
        pselx_d     = 3'b000;
        penable_d   = 1'b0;
        hreadyout_d = 1'b1;
        case (state_q)
            ST_IDLE, ST_RENABLE, ST_WENABLE: begin
                if (valid && !Hwrite) begin
                    state_d     = ST_READ;
                    paddr_d     = Haddr;
                    pwrite_d    = 1'b0;
                    pselx_d     = tempselx;
                    hreadyout_d = 1'b0;
                end else if (valid) begin
                    state_d = ST_WWAIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WWAIT: begin
                state_d     = valid ? ST_WRITEP : ST_WRITE;
                paddr_d     = Haddr1;
                pwdata_d    = Hwdata;
                pwrite_d    = 1'b1;
                pselx_d     = tempselx;
                hreadyout_d = 1'b0;
            end
            ST_READ: begin
                state_d   = ST_RENABLE;
                pselx_d   = pselx_q;
                penable_d = 1'b1;
            end
            ST_WRITE: begin
                state_d   = valid ? ST_WENABLEP : ST_WENABLE;
                pselx_d   = pselx_q;
                penable_d = 1'b1;
            end
            ST_WRITEP: begin
                state_d   = ST_WENABLEP;
                pselx_d   = pselx_q;
                penable_d = 1'b1;
            end
            ST_WENABLEP: begin
                // Hwritereg decides direction; valid only picks WRITE vs WRITEP.
                paddr_d     = Haddr2;
                pselx_d     = tempselx;
                hreadyout_d = 1'b0;
                if (Hwritereg) begin
                    state_d  = valid ? ST_WRITEP : ST_WRITE;
                    pwdata_d = Hwdata;
                    pwrite_d = 1'b1;
                end else begin
                    state_d  = ST_READ;
                    pwrite_d = 1'b0;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                paddr_d  = 32'h0;
                pwdata_d = 32'h0;
                pwrite_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-high reset.
    always_ff @(posedge Hclk) begin
        if (Hresetn) begin
            state_q     <= ST_IDLE;
            paddr_q     <= 32'h0;
            pwdata_q    <= 32'h0;
            pwrite_q    <= 1'b0;
            pselx_q     <= 3'b000;
            penable_q   <= 1'b0;
            hreadyout_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            pwrite_q    <= pwrite_d;
            pselx_q     <= pselx_d;
            penable_q   <= penable_d;
            hreadyout_q <= hreadyout_d;
        end
    end

    assign Pwrite    = pwrite_q;
    assign Penable   = penable_q;
    assign Pselx     = pselx_q;
    assign Paddr     = paddr_q;
    assign Pwdata    = pwdata_q;
    assign Hreadyout = hreadyout_q;

endmodule

// File: tb/tb_apb_fsm_controller.sv
// Bench for apb_fsm_controller: directed scenarios with literal expectations,
// then random traffic, all checked every cycle against a phase-level model.
module tb_apb_fsm_controller;

    logic        Hclk = 1'b0;
    logic        Hresetn = 1'b1;
    logic        valid = 1'b0;
    logic        Hwrite = 1'b0;
    logic        Hwritereg = 1'b0;
    logic [31:0] Haddr = 32'h0;
    logic [31:0] Haddr1 = 32'h0;
    logic [31:0] Haddr2 = 32'h0;
    logic [31:0] Hwdata = 32'h0;
    logic [31:0] Hwdata1 = 32'h0;
    logic [31:0] Hwdata2 = 32'h0;
    logic [31:0] Prdata = 32'h0;
    logic [2:0]  tempselx = 3'b000;
    logic        Pwrite;
    logic        Penable;
    logic [2:0]  Pselx;
    logic [31:0] Paddr;
    logic [31:0] Pwdata;
    logic        Hreadyout;

    int n_cmp = 0;
    int n_fail = 0;

    apb_fsm_controller dut (
        .Hclk(Hclk), .Hresetn(Hresetn), .valid(valid), .Hwrite(Hwrite),
        .Hwritereg(Hwritereg), .Haddr(Haddr), .Haddr1(Haddr1), .Haddr2(Haddr2),
        .Hwdata(Hwdata), .Hwdata1(Hwdata1), .Hwdata2(Hwdata2), .Prdata(Prdata),
        .tempselx(tempselx), .Pwrite(Pwrite), .Penable(Penable), .Pselx(Pselx),
        .Paddr(Paddr), .Pwdata(Pwdata), .Hreadyout(Hreadyout)
    );

    always #5 Hclk = ~Hclk;

    // Phase-level model: 0 = no transfer, 1 = waiting for write data,
    // 2 = APB setup, 3 = APB access. m_pipe marks an access phase that
    // chains straight into the next transfer taken from the Haddr2 stage.
    int          m_phase = 0;
    bit          m_wr = 0;
    bit          m_pipe = 0;
    bit          m_setup_pipe = 0;
    logic [31:0] e_paddr = 0, e_pwdata = 0;
    logic        e_pwrite = 0, e_pen = 0, e_rdy = 1;
    logic [2:0]  e_psel = 0;

    task automatic start_setup(bit wr, logic [31:0] addr, bit pipe);
        m_phase = 2; m_wr = wr; m_setup_pipe = pipe;
        e_paddr = addr; e_pwrite = wr;
        if (wr) e_pwdata = Hwdata;
        e_psel = tempselx; e_pen = 0; e_rdy = 0;
    endtask

    task automatic go_quiet(int ph);
        m_phase = ph; m_pipe = 0; e_psel = 0; e_pen = 0; e_rdy = 1;
    endtask

    task automatic accept_new();
        if (valid && !Hwrite) start_setup(0, Haddr, 0);
        else if (valid) go_quiet(1);
        else go_quiet(0);
    endtask

    task automatic model_edge();
        if (Hresetn) begin
            go_quiet(0);
            e_paddr = 0; e_pwdata = 0; e_pwrite = 0;
        end else begin
            case (m_phase)
                0: accept_new();
                1: start_setup(1, Haddr1, valid);
                2: begin
                    m_phase = 3; e_pen = 1; e_rdy = 1;
                    m_pipe = m_wr && (m_setup_pipe || valid);
                end
                default: begin
                    if (!m_pipe) accept_new();
                    else if (Hwritereg) start_setup(1, Haddr2, valid);
                    else start_setup(0, Haddr2, 0);
                end
            endcase
        end
    endtask

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("Paddr", Paddr, e_paddr);
        chk("Pwdata", Pwdata, e_pwdata);
        chk("Pwrite", 32'(Pwrite), 32'(e_pwrite));
        chk("Pselx", 32'(Pselx), 32'(e_psel));
        chk("Penable", 32'(Penable), 32'(e_pen));
        chk("Hreadyout", 32'(Hreadyout), 32'(e_rdy));
    endtask

    // One clock: model follows the edge, outputs checked 1 time unit later.
    task automatic step();
        @(posedge Hclk);
        model_edge();
        #1;
        compare_all();
    endtask

    // Literal expectation checked against both DUT and model.
    task automatic lit(string name, logic [31:0] dut_v, logic [31:0] mdl_v, logic [31:0] exp);
        chk({"lit_", name}, dut_v, exp);
        chk({"model_", name}, mdl_v, exp);
    endtask

    initial begin
        // Reset held two edges with valid high.
        Hresetn = 1; valid = 1;
        for (int i = 0; i < 2; i++) begin
            step();
            lit("rst_psel", 32'(Pselx), 32'(e_psel), 0);
            lit("rst_pen", 32'(Penable), 32'(e_pen), 0);
            lit("rst_paddr", Paddr, e_paddr, 0);
            lit("rst_rdy", 32'(Hreadyout), 32'(e_rdy), 1);
        end

        // Single read.
        Hresetn = 0; valid = 1; Hwrite = 0; Haddr = 32'hAAAAAAAA; tempselx = 3'b001;
        step();
        lit("rd1_paddr", Paddr, e_paddr, 32'hAAAAAAAA);
        lit("rd1_psel", 32'(Pselx), 32'(e_psel), 1);
        lit("rd1_pen", 32'(Penable), 32'(e_pen), 0);
        lit("rd1_rdy", 32'(Hreadyout), 32'(e_rdy), 0);
        valid = 0;
        step();
        lit("rd2_pen", 32'(Penable), 32'(e_pen), 1);
        lit("rd2_rdy", 32'(Hreadyout), 32'(e_rdy), 1);
        lit("rd2_psel", 32'(Pselx), 32'(e_psel), 1);
        step();
        lit("rd3_psel", 32'(Pselx), 32'(e_psel), 0);
        lit("rd3_pen", 32'(Penable), 32'(e_pen), 0);

        // Single write.
        valid = 1; Hwrite = 1; tempselx = 3'b010;
        step();
        lit("wr1_rdy", 32'(Hreadyout), 32'(e_rdy), 1);
        lit("wr1_psel", 32'(Pselx), 32'(e_psel), 0);
        valid = 0; Haddr1 = 32'hBBBBBBBB; Hwdata = 32'h87654321;
        step();
        lit("wr2_paddr", Paddr, e_paddr, 32'hBBBBBBBB);
        lit("wr2_pwdata", Pwdata, e_pwdata, 32'h87654321);
        lit("wr2_pwrite", 32'(Pwrite), 32'(e_pwrite), 1);
        lit("wr2_pen", 32'(Penable), 32'(e_pen), 0);
        lit("wr2_psel", 32'(Pselx), 32'(e_psel), 2);
        step();
        lit("wr3_pen", 32'(Penable), 32'(e_pen), 1);
        step();
        lit("wr4_psel", 32'(Pselx), 32'(e_psel), 0);
        lit("wr4_rdy", 32'(Hreadyout), 32'(e_rdy), 1);

        // Pipelined write.
        valid = 1; Hwrite = 1; Hwritereg = 1; tempselx = 3'b100;
        Haddr1 = 32'h11111111; Haddr2 = 32'hCCCCCCCC; Hwdata = 32'h5A5A0001;
        step();
        lit("pw_wwait_rdy", 32'(Hreadyout), 32'(e_rdy), 1);
        step();
        lit("pw_s1_paddr", Paddr, e_paddr, 32'h11111111);
        lit("pw_s1_rdy", 32'(Hreadyout), 32'(e_rdy), 0);
        step();
        lit("pw_e1_pen", 32'(Penable), 32'(e_pen), 1);
        Hwdata = 32'h5A5A0002;
        step();
        lit("pw_s2_paddr", Paddr, e_paddr, 32'hCCCCCCCC);
        lit("pw_s2_pwdata", Pwdata, e_pwdata, 32'h5A5A0002);
        lit("pw_s2_pen", 32'(Penable), 32'(e_pen), 0);
        step();
        lit("pw_e2_pen", 32'(Penable), 32'(e_pen), 1);

        // Write then read from the pipelined access phase.
        Hwritereg = 0; Haddr2 = 32'hDDDD0000;
        step();
        lit("wtr_paddr", Paddr, e_paddr, 32'hDDDD0000);
        lit("wtr_pwrite", 32'(Pwrite), 32'(e_pwrite), 0);
        lit("wtr_rdy", 32'(Hreadyout), 32'(e_rdy), 0);

        // Mid-transfer reset from the read access phase.
        valid = 0;
        step();
        lit("mr_pen_before", 32'(Penable), 32'(e_pen), 1);
        Hresetn = 1;
        step();
        lit("mr_pen", 32'(Penable), 32'(e_pen), 0);
        lit("mr_psel", 32'(Pselx), 32'(e_psel), 0);
        lit("mr_rdy", 32'(Hreadyout), 32'(e_rdy), 1);

        // Back-to-back reads: SETUP/ENABLE alternate with no idle cycle.
        Hresetn = 0; valid = 1; Hwrite = 0; tempselx = 3'b001;
        for (int i = 0; i < 6; i++) begin
            Haddr = 32'h1000 + 32'(i);
            step();
            lit("b2b_rdy", 32'(Hreadyout), 32'(e_rdy), (i % 2 == 0) ? 0 : 1);
            lit("b2b_pen", 32'(Penable), 32'(e_pen), (i % 2 == 0) ? 0 : 1);
        end

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            Hresetn   = ($urandom_range(0, 63) == 0);
            valid     = ($urandom_range(0, 3) != 0);
            Hwrite    = 1'($urandom_range(0, 1));
            Hwritereg = 1'($urandom_range(0, 1));
            Haddr     = $urandom;
            Haddr1    = $urandom;
            Haddr2    = $urandom;
            Hwdata    = $urandom;
            Hwdata1   = $urandom;
            Hwdata2   = $urandom;
            Prdata    = $urandom;
            tempselx  = 3'(1 << $urandom_range(0, 2));
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/apb_fsm_controller.md
# apb_fsm_controller

Control state machine of the AHB-to-APB bridge. It sits between the AHB slave interface, which supplies the registered and pipelined address/data copies and the decoded slave select, and the APB bus. It sequences APB SETUP and ENABLE phases for single and back-to-back reads and writes, including pipelined writes, and drives Hreadyout to stall the AHB master while an APB transfer is in progress.

## Interface
No parameters.
- Hclk  in  1  single clock; all state and outputs update on the rising edge
- Hresetn  in  1  reset: synchronous, active-high (asserted when 1), despite the name
- valid  in  1  a valid AHB transfer to the APB region is present this cycle
- Hwrite  in  1  current AHB direction (1 = write)
- Hwritereg  in  1  direction of the previous, registered transfer
- Haddr  in  32  current AHB address
- Haddr1  in  32  address registered one stage
- Haddr2  in  32  address registered two stages
- Hwdata  in  32  current AHB write data
- Hwdata1  in  32  write data registered one stage (unused)
- Hwdata2  in  32  write data registered two stages (unused)
- Prdata  in  32  APB read data; unused by the controller (the bridge top returns it to AHB)
- tempselx  in  3  one-hot decoded APB slave select
- Pwrite  out  1  APB direction
- Penable  out  1  APB enable phase
- Pselx  out  3  APB slave select
- Paddr  out  32  APB address
- Pwdata  out  32  APB write data
- Hreadyout  out  1  1 = bridge can accept an AHB transfer

## Operation
- There are 8 states: IDLE, WWAIT, READ, WRITE, WRITEP, RENABLE, WENABLE, WENABLEP.
- All outputs are registered. Each edge computes the next state and the next output values from the current state and inputs.
- Paddr, Pwdata and Pwrite hold their value unless the table below assigns them.
- Pselx, Penable and Hreadyout are assigned on every edge.
- Transitions, with the output values loaded on that edge:
  - IDLE, valid & !Hwrite → READ: Paddr=Haddr, Pwrite=0, Pselx=tempselx, Penable=0, Hreadyout=0.
  - IDLE, valid & Hwrite → WWAIT: Pselx=0, Penable=0, Hreadyout=1.
  - IDLE, !valid → IDLE: Pselx=0, Penable=0, Hreadyout=1.
  - WWAIT, !valid → WRITE; valid → WRITEP. Both load Paddr=Haddr1, Pwdata=Hwdata, Pwrite=1, Pselx=tempselx, Penable=0, Hreadyout=0.
  - READ → RENABLE: Penable=1, Hreadyout=1; Pselx held.
  - WRITE, !valid → WENABLE; valid → WENABLEP. Both load Penable=1, Hreadyout=1; Pselx held.
  - WRITEP → WENABLEP: Penable=1, Hreadyout=1; Pselx held.
  - RENABLE and WENABLE behave identically:
    - valid & !Hwrite → READ, with the IDLE→READ loads.
    - valid & Hwrite → WWAIT: Pselx=0, Penable=0, Hreadyout=1.
    - !valid → IDLE: Pselx=0, Penable=0, Hreadyout=1.
  - WENABLEP:
    - Hwritereg & !valid → WRITE; Hwritereg & valid → WRITEP. Both load Paddr=Haddr2, Pwdata=Hwdata, Pwrite=1, Pselx=tempselx, Penable=0, Hreadyout=0.
    - !Hwritereg → READ: Paddr=Haddr2, Pwrite=0, Pselx=tempselx, Penable=0, Hreadyout=0.
- No illegal states are reachable. Any unencoded state value goes to IDLE with the reset output values.

## Timing
- Reset, sampled at a rising edge while Hresetn=1:
  - state=IDLE, Paddr=0, Pwdata=0, Pwrite=0, Pselx=0, Penable=0, Hreadyout=1.
  - Reset overrides every transition, including mid-transfer (an active Penable drops on that edge).
- Read latency:
  - Edge 1, valid & !Hwrite sampled in IDLE: SETUP phase (Pselx set, Penable=0, Hreadyout=0).
  - Edge 2: ENABLE phase (Penable=1, Hreadyout=1).
- Write latency is one extra cycle, spent in WWAIT so Hwdata is available:
  - Edge 1: enter WWAIT.
  - Edge 2: SETUP phase.
  - Edge 3: ENABLE phase.
- Pselx stays constant across each SETUP→ENABLE pair.
- Penable is 1 only in RENABLE, WENABLE and WENABLEP.
- Hreadyout is 0 exactly during SETUP cycles (READ, WRITE, WRITEP).
- Back-to-back reads with valid held high and Hwrite=0 alternate READ/RENABLE: a 2-cycle period with no IDLE cycle.
- Simultaneous events: in WENABLEP, Hwritereg takes priority and valid only selects WRITE vs WRITEP; valid is ignored when Hwritereg=0.
- APB slaves are zero-wait-state; there is no Pready input.

## Test plan
- Reset: hold Hresetn=1 for 2 edges with valid=1 → state IDLE, Pselx=0, Penable=0, Paddr=0, Hreadyout=1 throughout.
- Single read:
  - Stimulus: Hresetn=0, valid=1, Hwrite=0, Haddr=0xAAAAAAAA, tempselx=001 for one edge, then valid=0.
  - Edge 1: Paddr=0xAAAAAAAA, Pselx=001, Penable=0, Hreadyout=0.
  - Edge 2: Penable=1, Hreadyout=1.
  - Edge 3: Pselx=0, Penable=0 (IDLE).
- Single write:
  - Stimulus: valid=1, Hwrite=1 for one edge, then valid=0, Haddr1=0xBBBBBBBB, Hwdata=0x87654321.
  - Edge 1: WWAIT, Hreadyout=1.
  - Edge 2: Paddr=0xBBBBBBBB, Pwdata=0x87654321, Pwrite=1, Penable=0.
  - Edge 3: Penable=1.
  - Edge 4: IDLE.
- Pipelined write:
  - Stimulus: valid held 1, Hwrite=1, Hwritereg=1, Haddr2=0xCCCCCCCC.
  - Path: WWAIT → WRITEP → WENABLEP → WRITEP, with Paddr=0xCCCCCCCC on the second SETUP.
- Write then read: in WENABLEP with Hwritereg=0 → READ, Paddr=Haddr2, Pwrite=0, Hreadyout=0.
- Mid-transfer reset: assert Hresetn=1 in RENABLE → the next edge gives Penable=0, Pselx=0, Hreadyout=1, IDLE.
